// File: rtl/ffa_pkg.sv
// Shared types and default sizes for the flip-flop register-file command scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ffa_pkg;

    localparam int FFA_DATA_W     = 8;
    localparam int FFA_ADDR_W     = 3;
    localparam int FFA_RESP_DEPTH = 4;

    // Which request type owns the array port in a cycle
    typedef enum logic {
        GNT_WR = 1'b0,
        GNT_RD = 1'b1
    } gnt_e;

    // One queued read response: error flag above the data
    typedef struct packed {
        logic                  err;
        logic [FFA_DATA_W-1:0] data;
    } ffa_rsp_t;

endpackage

// File: rtl/ffa_rsp_fifo.sv
// Synchronous response FIFO with binary wrap pointers; head word is read straight from flops.
// Latency: a push at the end of cycle N is visible at the head (empty=0) from cycle N+1.
// Backpressure: push is ignored while full; pop is ignored while empty.
module ffa_rsp_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    output logic             full,
    input  logic             pop,
    output logic             empty,
    output logic [WIDTH-1:0] head_dat
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];

    // Storage and pointers; storage is cleared so the head reads zero after reset
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push && !full) begin
                mem[wr_ptr[AW-1:0]] <= push_dat;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Status from pointer compare: full when only the wrap bit differs
    always_comb begin
        empty    = (wr_ptr == rd_ptr);
        full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        head_dat = mem[rd_ptr[AW-1:0]];
    end

endmodule

// File: rtl/ffa_cmd_sched.sv
// Arbitrates write/read request streams onto the register-file array port and queues read responses.
// Latency: grant is combinational in the request cycle; read response valid the cycle after acceptance.
// Backpressure: reads stall while the response FIFO is full, writes keep flowing. Option: FFA_CMD_SCHED_STATS_EN.
module ffa_cmd_sched
    import ffa_pkg::*;
#(
    parameter int DATA_W     = FFA_DATA_W,
    parameter int ADDR_W     = FFA_ADDR_W,
    parameter int RESP_DEPTH = FFA_RESP_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wq_valid,
    output logic              wq_ready,
    input  logic [ADDR_W-1:0] wq_addr,
    input  logic [DATA_W-1:0] wq_data,
    input  logic              rq_valid,
    output logic              rq_ready,
    input  logic [ADDR_W-1:0] rq_addr,
    output logic              arr_wr,
    output logic              arr_rd,
    output logic [ADDR_W-1:0] arr_addr,
    output logic [DATA_W-1:0] arr_din,
    input  logic [DATA_W-1:0] arr_dout,
    input  logic              arr_error,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err
`ifdef FFA_CMD_SCHED_STATS_EN
    ,
    output logic [31:0]       stat_wr_cnt,
    output logic [31:0]       stat_rd_cnt,
    output logic [15:0]       stat_err_cnt
`endif
);

    gnt_e              rr_last;
    logic              wr_elig;
    logic              rd_elig;
    logic              gnt_wr;
    logic              gnt_rd;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_pop;
    logic [DATA_W:0]   push_word;
    logic [DATA_W:0]   head_word;

    // Arbitration: same-address conflicts go to the write so a read never overtakes it
    always_comb begin
        gnt_wr  = 1'b0;
        gnt_rd  = 1'b0;
        wr_elig = wq_valid;
        rd_elig = rq_valid && !fifo_full;
        if (!reset) begin
            if (wr_elig && rd_elig) begin
                if ((wq_addr == rq_addr) || (rr_last == GNT_RD)) begin
                    gnt_wr = 1'b1;
                end else begin
                    gnt_rd = 1'b1;
                end
            end else begin
                gnt_wr = wr_elig;
                gnt_rd = rd_elig;
            end
        end
    end

    // Array port drive; idle fields are zeroed rather than left floating
    always_comb begin
        wq_ready = gnt_wr;
        rq_ready = gnt_rd;
        arr_wr   = gnt_wr;
        arr_rd   = gnt_rd;
        arr_addr = '0;
        arr_din  = '0;
        if (gnt_wr) begin
            arr_addr = wq_addr;
            arr_din  = wq_data;
        end else if (gnt_rd) begin
            arr_addr = rq_addr;
        end
    end

    // Round-robin history, advanced only when something is granted
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_last <= GNT_RD;
        end else if (gnt_wr) begin
            rr_last <= GNT_WR;
        end else if (gnt_rd) begin
            rr_last <= GNT_RD;
        end
    end

    // Read data and error are sampled in the same cycle the read strobe is issued
    always_comb begin
        push_word = {arr_error, arr_dout};
        fifo_pop  = rsp_valid && rsp_ready;
        rsp_valid = !fifo_empty;
        rsp_err   = head_word[DATA_W];
        rsp_data  = head_word[DATA_W-1:0];
    end

    ffa_rsp_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (RESP_DEPTH)
    ) u_rsp_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (gnt_rd),
        .push_dat (push_word),
        .full     (fifo_full),
        .pop      (fifo_pop),
        .empty    (fifo_empty),
        .head_dat (head_word)
    );

`ifdef FFA_CMD_SCHED_STATS_EN
    logic [31:0] stat_wr_cnt_q;
    logic [31:0] stat_rd_cnt_q;
    logic [15:0] stat_err_cnt_q;

    // Saturating event counters; they stick at all-ones instead of wrapping
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_wr_cnt_q  <= '0;
            stat_rd_cnt_q  <= '0;
            stat_err_cnt_q <= '0;
        end else begin
            if (gnt_wr && (stat_wr_cnt_q != '1)) begin
                stat_wr_cnt_q <= stat_wr_cnt_q + 32'd1;
            end
            if (gnt_rd && (stat_rd_cnt_q != '1)) begin
                stat_rd_cnt_q <= stat_rd_cnt_q + 32'd1;
            end
            if (gnt_rd && arr_error && (stat_err_cnt_q != '1)) begin
                stat_err_cnt_q <= stat_err_cnt_q + 16'd1;
            end
        end
    end

    // Counters exported as-is
    always_comb begin
        stat_wr_cnt  = stat_wr_cnt_q;
        stat_rd_cnt  = stat_rd_cnt_q;
        stat_err_cnt = stat_err_cnt_q;
    end
`endif

endmodule

// File: tb/tb_ffa_cmd_sched.sv
// Directed bench for ffa_cmd_sched with an array model and a response scoreboard.
// Latency: inputs change 1ns after the rising edge, direct checks 2ns after it, scoreboard on the falling edge.
// Backpressure: rsp_ready is driven per step to exercise FIFO full and drain.
module tb_ffa_cmd_sched;

    localparam int DW = 8;
    localparam int AW = 3;

    typedef struct packed {
        logic          err;
        logic [DW-1:0] data;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          wq_valid, wq_ready, rq_valid, rq_ready;
    logic [AW-1:0] wq_addr, rq_addr, arr_addr;
    logic [DW-1:0] wq_data, arr_din, arr_dout, rsp_data;
    logic          arr_wr, arr_rd, arr_error, rsp_valid, rsp_ready, rsp_err;
    logic          err_inj;
`ifdef FFA_CMD_SCHED_STATS_EN
    logic [31:0]   stat_wr_cnt, stat_rd_cnt;
    logic [15:0]   stat_err_cnt;
    int            wr_seen = 0;
    int            rd_seen = 0;
`endif

    int            checks = 0;
    int            errors = 0;
    exp_t          sb[$];

    logic [DW-1:0] am      [8] = '{8'h50, 8'h51, 8'h52, 8'h53, 8'h54, 8'h55, 8'h56, 8'h57};
    logic [DW-1:0] ref_mem [8] = '{8'h50, 8'h51, 8'h52, 8'h53, 8'h54, 8'h55, 8'h56, 8'h57};

    always #5 clk = ~clk;

    ffa_cmd_sched dut (
        .clk       (clk),
        .reset     (reset),
        .wq_valid  (wq_valid),
        .wq_ready  (wq_ready),
        .wq_addr   (wq_addr),
        .wq_data   (wq_data),
        .rq_valid  (rq_valid),
        .rq_ready  (rq_ready),
        .rq_addr   (rq_addr),
        .arr_wr    (arr_wr),
        .arr_rd    (arr_rd),
        .arr_addr  (arr_addr),
        .arr_din   (arr_din),
        .arr_dout  (arr_dout),
        .arr_error (arr_error),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err)
`ifdef FFA_CMD_SCHED_STATS_EN
        ,
        .stat_wr_cnt  (stat_wr_cnt),
        .stat_rd_cnt  (stat_rd_cnt),
        .stat_err_cnt (stat_err_cnt)
`endif
    );

    // Register-file array model: combinational read, write on the rising edge
    assign arr_dout  = am[arr_addr];
    assign arr_error = err_inj;
    always @(posedge clk) begin
        if (arr_wr) am[arr_addr] <= arr_din;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: expectations from the bench's own request stream, compared on each response pop
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (rsp_valid && rsp_ready) begin
                chk("rsp_expected", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("sb_rsp_data", 32'(rsp_data), 32'(e.data));
                    chk("sb_rsp_err", 32'(rsp_err), 32'(e.err));
                end
            end
            if (wq_valid && wq_ready) begin
                ref_mem[wq_addr] = wq_data;
`ifdef FFA_CMD_SCHED_STATS_EN
                wr_seen++;
`endif
            end
            if (rq_valid && rq_ready) begin
                sb.push_back('{err: err_inj, data: ref_mem[rq_addr]});
`ifdef FFA_CMD_SCHED_STATS_EN
                rd_seen++;
`endif
            end
        end
    end

    initial begin
        wq_valid = 1'b1; rq_valid = 1'b1; wq_addr = 3'd1; wq_data = 8'h11;
        rq_addr = 3'd2; rsp_ready = 1'b0; err_inj = 1'b0;

        // Reset held three cycles with both requests pending
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #2;
            chk("rst_wq_ready", 32'(wq_ready), 32'd0);
            chk("rst_rq_ready", 32'(rq_ready), 32'd0);
            chk("rst_arr_wr", 32'(arr_wr), 32'd0);
            chk("rst_arr_rd", 32'(arr_rd), 32'd0);
            chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        end
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);

        // First conflict after reset goes to the write
        @(posedge clk); #1 reset = 1'b0; #1;
        chk("first_wq_ready", 32'(wq_ready), 32'd1);
        chk("first_rq_ready", 32'(rq_ready), 32'd0);
        chk("first_arr_addr", 32'(arr_addr), 32'd1);
        chk("first_arr_din", 32'(arr_din), 32'h11);

        @(posedge clk); #1 wq_valid = 1'b0; rq_valid = 1'b0; #1;
        chk("idle_strobes", 32'({arr_wr, arr_rd}), 32'd0);
        chk("idle_arr_addr", 32'(arr_addr), 32'd0);
        chk("idle_arr_din", 32'(arr_din), 32'd0);

        // Write then read back the same address
        @(posedge clk); #1 wq_valid = 1'b1; wq_addr = 3'd5; wq_data = 8'hA7; #1;
        chk("wr_arr_wr", 32'(arr_wr), 32'd1);
        chk("wr_arr_addr", 32'(arr_addr), 32'd5);
        chk("wr_arr_din", 32'(arr_din), 32'hA7);
        @(posedge clk); #1 wq_valid = 1'b0; rq_valid = 1'b1; rq_addr = 3'd5; #1;
        chk("rd_arr_rd", 32'(arr_rd), 32'd1);
        chk("rd_arr_wr", 32'(arr_wr), 32'd0);
        chk("rd_arr_addr", 32'(arr_addr), 32'd5);
        chk("rd_arr_din", 32'(arr_din), 32'd0);
        chk("rd_rsp_valid_n", 32'(rsp_valid), 32'd0);
        @(posedge clk); #1 rq_valid = 1'b0; rsp_ready = 1'b1; #1;
        chk("rd_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("rd_rsp_data", 32'(rsp_data), 32'hA7);
        chk("rd_rsp_err", 32'(rsp_err), 32'd0);
        @(posedge clk); #2;
        chk("rd_drained", 32'(rsp_valid), 32'd0);

        // Round-robin on differing addresses: last grant was a read, so W,R,W,R
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1 wq_valid = 1'b1; rq_valid = 1'b1;
            wq_addr = 3'd2; wq_data = 8'h22; rq_addr = 3'd3; #1;
            chk("rr_wq_ready", 32'(wq_ready), 32'(i % 2 == 0));
            chk("rr_rq_ready", 32'(rq_ready), 32'(i % 2 == 1));
            chk("rr_exclusive", 32'(arr_wr & arr_rd), 32'd0);
        end

        // Same address: a write-only cycle makes RR favour the read, yet the write must win
        @(posedge clk); #1 rq_valid = 1'b0; wq_addr = 3'd7; wq_data = 8'h77; #1;
        chk("raw_pre_wr", 32'(wq_ready), 32'd1);
        @(posedge clk); #1 rq_valid = 1'b1; wq_addr = 3'd4; wq_data = 8'h44; rq_addr = 3'd4; #1;
        chk("raw_wq_ready", 32'(wq_ready), 32'd1);
        chk("raw_rq_ready", 32'(rq_ready), 32'd0);
        @(posedge clk); #1 wq_valid = 1'b0; #1;
        chk("raw_rd_follows", 32'(rq_ready), 32'd1);
        @(posedge clk); #1 rq_valid = 1'b0; #1;
        chk("raw_rsp_data", 32'(rsp_data), 32'h44);

        // FIFO full: four reads fill it, the fifth stalls while a write still goes through
        @(posedge clk); #1 rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1 rq_valid = 1'b1; rq_addr = 3'(i); #1;
            chk("fill_rq_ready", 32'(rq_ready), 32'd1);
        end
        @(posedge clk); #1 rq_addr = 3'd4; wq_valid = 1'b1; wq_addr = 3'd6; wq_data = 8'h66; #1;
        chk("full_rq_ready", 32'(rq_ready), 32'd0);
        chk("full_wq_ready", 32'(wq_ready), 32'd1);
        chk("full_arr_wr", 32'(arr_wr), 32'd1);
        @(posedge clk); #1 wq_valid = 1'b0; rsp_ready = 1'b1; #1;
        chk("full_pop_no_space", 32'(rq_ready), 32'd0);
        chk("full_rsp_valid", 32'(rsp_valid), 32'd1);
        @(posedge clk); #2;
        chk("fifth_rq_ready", 32'(rq_ready), 32'd1);
        @(posedge clk); #1 rq_valid = 1'b0;
        for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
        #1 chk("drain_empty", 32'(sb.size()), 32'd0);

        // Error capture
        @(posedge clk); #1 rq_valid = 1'b1; rq_addr = 3'd5; err_inj = 1'b1; #1;
        chk("err_rq_ready", 32'(rq_ready), 32'd1);
`ifdef FFA_CMD_SCHED_STATS_EN
        chk("stat_err_before", 32'(stat_err_cnt), 32'd0);
`endif
        @(posedge clk); #1 rq_valid = 1'b0; err_inj = 1'b0; #1;
        chk("err_rsp_err", 32'(rsp_err), 32'd1);
        chk("err_rsp_data", 32'(rsp_data), 32'hA7);
`ifdef FFA_CMD_SCHED_STATS_EN
        chk("stat_err_after", 32'(stat_err_cnt), 32'd1);
        chk("stat_rd_cnt", stat_rd_cnt, 32'(rd_seen));
        chk("stat_wr_cnt", stat_wr_cnt, 32'(wr_seen));
        @(posedge clk); #1 force dut.stat_wr_cnt_q = 32'hFFFF_FFFF;
        #1 release dut.stat_wr_cnt_q;
        wq_valid = 1'b1; wq_addr = 3'd0; wq_data = 8'h99;
        @(posedge clk); #1 wq_valid = 1'b0; #1;
        chk("stat_wr_saturate", stat_wr_cnt, 32'hFFFF_FFFF);
`endif

        // Reset mid-operation: pending response dropped, no access during reset
        @(posedge clk); #1 rsp_ready = 1'b0; rq_valid = 1'b1; rq_addr = 3'd1; #1;
        chk("mid_rq_ready", 32'(rq_ready), 32'd1);
        @(posedge clk); #1 reset = 1'b1; wq_valid = 1'b1; #1;
        sb.delete();
        chk("mid_rst_strobes", 32'({arr_wr, arr_rd}), 32'd0);
        chk("mid_rst_ready", 32'({wq_ready, rq_ready}), 32'd0);
        @(posedge clk); #1 reset = 1'b0; wq_valid = 1'b0; rq_valid = 1'b0; #1;
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_rsp_data", 32'(rsp_data), 32'd0);

        @(posedge clk); #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
